// File: rtl/ladybird_config.sv
// Core-wide configuration: datapath width and shared FSM state types.
package ladybird_config;

   localparam int unsigned XLEN = 32;

   // Load/store unit sequencing states
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2,
      RESP = 2'd3
   } lsu_state_t;

endpackage

// File: rtl/ladybird_riscv_helper.sv
// RISC-V encoding constants shared by the core.
package ladybird_riscv_helper;

   // Load/store funct3 width/sign encodings
   localparam logic [2:0] FUNCT3_B  = 3'b000;
   localparam logic [2:0] FUNCT3_H  = 3'b001;
   localparam logic [2:0] FUNCT3_W  = 3'b010;
   localparam logic [2:0] FUNCT3_BU = 3'b100;
   localparam logic [2:0] FUNCT3_HU = 3'b101;

endpackage

// File: rtl/ladybird_lsu_align.sv
// Byte-lane logic for the LSU: store replication/strobes, load extraction/extension,
// and request legality checks. Purely combinational.
module ladybird_lsu_align
   import ladybird_riscv_helper::*;
#(
   parameter int unsigned XLEN = ladybird_config::XLEN
) (
   input  logic [1:0]      req_addr,
   input  logic [2:0]      req_funct,
   input  logic            req_we,
   input  logic [XLEN-1:0] req_data,
   output logic [XLEN-1:0] st_wdata,
   output logic [3:0]      st_strb,
   output logic            misaligned,
   output logic            illegal,
   input  logic [1:0]      ld_addr,
   input  logic [2:0]      ld_funct,
   input  logic [XLEN-1:0] ld_rdata,
   output logic [XLEN-1:0] ld_data
);

   logic [XLEN-1:0] ld_shifted;
   logic [15:0]     ld_half;

   // Legality: stores only allow B/H/W, loads additionally BU/HU
   always_comb begin
      illegal    = 1'b0;
      misaligned = 1'b0;
      if (req_we) begin
         illegal = !(req_funct inside {FUNCT3_B, FUNCT3_H, FUNCT3_W});
      end else begin
         illegal = !(req_funct inside {FUNCT3_B, FUNCT3_H, FUNCT3_W, FUNCT3_BU, FUNCT3_HU});
      end
      // funct3[1:0] encodes access size for both signed and unsigned forms
      case (req_funct[1:0])
         2'b01:   misaligned = req_addr[0];
         2'b10:   misaligned = (req_addr != 2'b00);
         default: misaligned = 1'b0;
      endcase
   end

   // Store lane replication so the bus can pick any lane with the strobes
   always_comb begin
      st_wdata = '0;
      st_strb  = 4'b0000;
      if (req_we) begin
         case (req_funct)
            FUNCT3_B: begin
               st_wdata = {4{req_data[7:0]}};
               st_strb  = 4'b0001 << req_addr;
            end
            FUNCT3_H: begin
               st_wdata = {2{req_data[15:0]}};
               st_strb  = req_addr[1] ? 4'b1100 : 4'b0011;
            end
            FUNCT3_W: begin
               st_wdata = req_data;
               st_strb  = 4'b1111;
            end
            default: begin
               st_wdata = '0;
               st_strb  = 4'b0000;
            end
         endcase
      end
   end

   // Load lane extraction and sign/zero extension
   always_comb begin
      ld_shifted = ld_rdata >> {ld_addr, 3'b000};
      ld_half    = ld_addr[1] ? ld_rdata[31:16] : ld_rdata[15:0];
      case (ld_funct)
         FUNCT3_B:  ld_data = {{24{ld_shifted[7]}}, ld_shifted[7:0]};
         FUNCT3_H:  ld_data = {{16{ld_half[15]}}, ld_half};
         FUNCT3_W:  ld_data = ld_rdata;
         FUNCT3_BU: ld_data = {24'd0, ld_shifted[7:0]};
         FUNCT3_HU: ld_data = {16'd0, ld_half};
         default:   ld_data = '0;
      endcase
   end

endmodule

// File: rtl/ladybird_lsu.sv
// Load/store unit: one request per handshake, converted to an aligned word bus access,
// with error responses for illegal/misaligned requests and bus timeouts.
module ladybird_lsu
   import ladybird_config::*;
#(
   parameter int unsigned XLEN           = ladybird_config::XLEN,
   parameter int unsigned TIMEOUT_CYCLES = 256
) (
   input  logic            clk,
   input  logic            nrst,
   input  logic            i_valid,
   output logic            i_ready,
   input  logic [XLEN-1:0] i_addr,
   input  logic [XLEN-1:0] i_data,
   input  logic            i_we,
   input  logic [2:0]      i_funct,
   output logic            o_valid,
   input  logic            o_ready,
   output logic [XLEN-1:0] o_data,
   output logic            o_error,
   output logic            bus_req,
   input  logic            bus_gnt,
   output logic [XLEN-1:0] bus_addr,
   output logic            bus_we,
   output logic [XLEN-1:0] bus_wdata,
   output logic [3:0]      bus_strb,
   input  logic            bus_rvalid,
   input  logic [XLEN-1:0] bus_rdata
);

   localparam int unsigned    CntW    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CntW-1:0] CntLast =
      CntW'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

   lsu_state_t      state_q, state_d;
   logic [1:0]      addr_lo_q;
   logic [2:0]      funct_q;
   logic            we_q;
   logic [XLEN-1:0] bus_addr_q;
   logic            bus_we_q;
   logic [XLEN-1:0] bus_wdata_q;
   logic [3:0]      bus_strb_q;
   logic [XLEN-1:0] o_data_q;
   logic            o_error_q;
   logic [CntW-1:0] cnt_q;

   logic [XLEN-1:0] st_wdata;
   logic [3:0]      st_strb;
   logic            misaligned;
   logic            illegal;
   logic [XLEN-1:0] ld_data;
   logic            req_bad;
   logic            timeout_hit;

   ladybird_lsu_align #(
      .XLEN (XLEN)
   ) u_align (
      .req_addr   (i_addr[1:0]),
      .req_funct  (i_funct),
      .req_we     (i_we),
      .req_data   (i_data),
      .st_wdata   (st_wdata),
      .st_strb    (st_strb),
      .misaligned (misaligned),
      .illegal    (illegal),
      .ld_addr    (addr_lo_q),
      .ld_funct   (funct_q),
      .ld_rdata   (bus_rdata),
      .ld_data    (ld_data)
   );

   assign req_bad     = illegal | misaligned;
   assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == CntLast);

   // Outputs come only from registers or decoded state
   assign i_ready   = (state_q == IDLE);
   assign o_valid   = (state_q == RESP);
   assign bus_req   = (state_q == REQ);
   assign o_data    = o_data_q;
   assign o_error   = o_error_q;
   assign bus_addr  = bus_addr_q;
   assign bus_we    = bus_we_q;
   assign bus_wdata = bus_wdata_q;
   assign bus_strb  = bus_strb_q;

   // Next-state: timeout beats a grant in REQ, completion beats timeout in WAIT
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: if (i_valid) state_d = req_bad ? RESP : REQ;
         REQ: begin
            if (timeout_hit)  state_d = RESP;
            else if (bus_gnt) state_d = WAIT;
         end
         WAIT: if (bus_rvalid || timeout_hit) state_d = RESP;
         RESP: if (o_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // State, request, response and timeout registers
   always_ff @(posedge clk) begin
      if (!nrst) begin
         state_q     <= IDLE;
         addr_lo_q   <= 2'b00;
         funct_q     <= 3'b000;
         we_q        <= 1'b0;
         bus_addr_q  <= '0;
         bus_we_q    <= 1'b0;
         bus_wdata_q <= '0;
         bus_strb_q  <= 4'b0000;
         o_data_q    <= '0;
         o_error_q   <= 1'b0;
         cnt_q       <= '0;
      end else begin
         state_q <= state_d;
         unique case (state_q)
            IDLE: begin
               cnt_q <= '0;
               if (i_valid) begin
                  o_data_q <= '0;
                  if (req_bad) begin
                     o_error_q <= 1'b1;
                  end else begin
                     o_error_q   <= 1'b0;
                     addr_lo_q   <= i_addr[1:0];
                     funct_q     <= i_funct;
                     we_q        <= i_we;
                     bus_addr_q  <= {i_addr[XLEN-1:2], 2'b00};
                     bus_we_q    <= i_we;
                     bus_wdata_q <= st_wdata;
                     bus_strb_q  <= st_strb;
                  end
               end
            end
            REQ, WAIT: begin
               cnt_q <= cnt_q + CntW'(1);
               if (state_q == WAIT && bus_rvalid) begin
                  o_data_q  <= we_q ? '0 : ld_data;
                  o_error_q <= 1'b0;
               end else if (timeout_hit) begin
                  o_data_q  <= '0;
                  o_error_q <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_ladybird_lsu.sv
// Self-checking bench for ladybird_lsu: table-driven accesses plus timeout/stall/reset sequences.
module tb_ladybird_lsu;

   logic        clk = 1'b0;
   logic        nrst = 1'b0;
   logic        i_valid = 1'b0;
   logic        i_ready;
   logic [31:0] i_addr = '0;
   logic [31:0] i_data = '0;
   logic        i_we = 1'b0;
   logic [2:0]  i_funct = '0;
   logic        o_valid;
   logic        o_ready = 1'b1;
   logic [31:0] o_data;
   logic        o_error;
   logic        bus_req;
   logic        bus_gnt = 1'b0;
   logic [31:0] bus_addr;
   logic        bus_we;
   logic [31:0] bus_wdata;
   logic [3:0]  bus_strb;
   logic        bus_rvalid = 1'b0;
   logic [31:0] bus_rdata = '0;

   always #5 clk = ~clk;

   ladybird_lsu #(
      .XLEN           (32),
      .TIMEOUT_CYCLES (8)
   ) dut (
      .clk        (clk),
      .nrst       (nrst),
      .i_valid    (i_valid),
      .i_ready    (i_ready),
      .i_addr     (i_addr),
      .i_data     (i_data),
      .i_we       (i_we),
      .i_funct    (i_funct),
      .o_valid    (o_valid),
      .o_ready    (o_ready),
      .o_data     (o_data),
      .o_error    (o_error),
      .bus_req    (bus_req),
      .bus_gnt    (bus_gnt),
      .bus_addr   (bus_addr),
      .bus_we     (bus_we),
      .bus_wdata  (bus_wdata),
      .bus_strb   (bus_strb),
      .bus_rvalid (bus_rvalid),
      .bus_rdata  (bus_rdata)
   );

   typedef struct {
      logic        we;
      logic [2:0]  funct;
      logic [31:0] addr;
      logic [31:0] din;
      logic [31:0] rdata;
      logic        exp_err;
      logic [31:0] exp_data;
      logic [31:0] exp_baddr;
      logic [31:0] exp_wdata;
      logic [3:0]  exp_strb;
   } vec_t;

   typedef struct packed {
      logic        err;
      logic [31:0] data;
   } resp_t;

   resp_t sb_q[$];
   int    checks = 0;
   int    errors = 0;
   vec_t  vecs[17];

   function automatic vec_t mk(input logic we, input logic [2:0] funct,
                               input logic [31:0] addr, input logic [31:0] din,
                               input logic [31:0] rdata, input logic exp_err,
                               input logic [31:0] exp_data, input logic [31:0] exp_baddr,
                               input logic [31:0] exp_wdata, input logic [3:0] exp_strb);
      vec_t v;
      v.we = we; v.funct = funct; v.addr = addr; v.din = din; v.rdata = rdata;
      v.exp_err = exp_err; v.exp_data = exp_data; v.exp_baddr = exp_baddr;
      v.exp_wdata = exp_wdata; v.exp_strb = exp_strb;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_resp(input string name);
      resp_t e;
      if (sb_q.size() == 0) begin
         checks++;
         errors++;
         $display("FAIL %s: response seen with empty scoreboard", name);
      end else begin
         e = sb_q.pop_front();
         chk({name, " o_error"}, 32'(o_error), 32'(e.err));
         chk({name, " o_data"}, o_data, e.data);
      end
   endtask

   task automatic drive_req(input logic we, input logic [2:0] funct, input logic [31:0] addr,
                            input logic [31:0] din);
      i_valid = 1'b1;
      i_we    = we;
      i_funct = funct;
      i_addr  = addr;
      i_data  = din;
   endtask

   // Full transaction: gnt one cycle after acceptance, rvalid the cycle after that
   task automatic do_access(input vec_t v, input string name);
      drive_req(v.we, v.funct, v.addr, v.din);
      sb_q.push_back('{err: v.exp_err, data: v.exp_data});
      chk({name, " i_ready"}, 32'(i_ready), 32'd1);
      step();
      i_valid = 1'b0;
      i_data  = $urandom;
      i_addr  = $urandom;
      if (v.exp_err) begin
         chk({name, " no bus_req"}, 32'(bus_req), 32'd0);
         chk({name, " o_valid cycle1"}, 32'(o_valid), 32'd1);
      end else begin
         chk({name, " bus_req"}, 32'(bus_req), 32'd1);
         chk({name, " bus_addr"}, bus_addr, v.exp_baddr);
         chk({name, " bus_we"}, 32'(bus_we), 32'(v.we));
         chk({name, " bus_strb"}, 32'(bus_strb), 32'(v.exp_strb));
         if (v.we) chk({name, " bus_wdata"}, bus_wdata, v.exp_wdata);
         bus_gnt = 1'b1;
         step();
         bus_gnt = 1'b0;
         chk({name, " bus_req dropped"}, 32'(bus_req), 32'd0);
         chk({name, " no early o_valid"}, 32'(o_valid), 32'd0);
         bus_rvalid = 1'b1;
         bus_rdata  = v.rdata;
         step();
         bus_rvalid = 1'b0;
         bus_rdata  = $urandom;
         chk({name, " o_valid cycle3"}, 32'(o_valid), 32'd1);
      end
      if (o_valid) check_resp(name);
      step();
      chk({name, " o_valid one cycle"}, 32'(o_valid), 32'd0);
      chk({name, " i_ready back"}, 32'(i_ready), 32'd1);
   endtask

   task automatic check_reset_values(input string name);
      chk({name, " i_ready"}, 32'(i_ready), 32'd1);
      chk({name, " o_valid"}, 32'(o_valid), 32'd0);
      chk({name, " o_error"}, 32'(o_error), 32'd0);
      chk({name, " o_data"}, o_data, 32'd0);
      chk({name, " bus_req"}, 32'(bus_req), 32'd0);
      chk({name, " bus_we"}, 32'(bus_we), 32'd0);
      chk({name, " bus_addr"}, bus_addr, 32'd0);
      chk({name, " bus_wdata"}, bus_wdata, 32'd0);
      chk({name, " bus_strb"}, 32'(bus_strb), 32'd0);
   endtask

   initial begin
      int          n;
      logic [31:0] held_data;

      //            we  f     addr       din           rdata         err exp_data      baddr      wdata         strb
      vecs[0]  = mk(0, 3'd2, 32'h100, 32'h0,        32'hDEADBEEF, 0, 32'hDEADBEEF, 32'h100, 32'h0,        4'b0000);
      vecs[1]  = mk(0, 3'd0, 32'h103, 32'h0,        32'h80FF0000, 0, 32'hFFFFFF80, 32'h100, 32'h0,        4'b0000);
      vecs[2]  = mk(0, 3'd4, 32'h103, 32'h0,        32'h80FF0000, 0, 32'h00000080, 32'h100, 32'h0,        4'b0000);
      vecs[3]  = mk(0, 3'd1, 32'h102, 32'h0,        32'h80FF0000, 0, 32'hFFFF80FF, 32'h100, 32'h0,        4'b0000);
      vecs[4]  = mk(0, 3'd5, 32'h102, 32'h0,        32'h80FF0000, 0, 32'h000080FF, 32'h100, 32'h0,        4'b0000);
      vecs[5]  = mk(0, 3'd0, 32'h101, 32'h0,        32'h1234A5C3, 0, 32'hFFFFFFA5, 32'h100, 32'h0,        4'b0000);
      vecs[6]  = mk(0, 3'd1, 32'h100, 32'h0,        32'h1234A5C3, 0, 32'hFFFFA5C3, 32'h100, 32'h0,        4'b0000);
      vecs[7]  = mk(1, 3'd0, 32'h201, 32'h12345678, 32'hFFFFFFFF, 0, 32'h0,        32'h200, 32'h78787878, 4'b0010);
      vecs[8]  = mk(1, 3'd1, 32'h202, 32'h12345678, 32'hFFFFFFFF, 0, 32'h0,        32'h200, 32'h56785678, 4'b1100);
      vecs[9]  = mk(1, 3'd2, 32'h204, 32'hCAFEF00D, 32'hFFFFFFFF, 0, 32'h0,        32'h204, 32'hCAFEF00D, 4'b1111);
      vecs[10] = mk(1, 3'd0, 32'h203, 32'h000000AB, 32'hFFFFFFFF, 0, 32'h0,        32'h200, 32'hABABABAB, 4'b1000);
      vecs[11] = mk(0, 3'd2, 32'h102, 32'h0,        32'h0,        1, 32'h0,        32'h0,   32'h0,        4'b0000);
      vecs[12] = mk(0, 3'd3, 32'h100, 32'h0,        32'h0,        1, 32'h0,        32'h0,   32'h0,        4'b0000);
      vecs[13] = mk(1, 3'd4, 32'h100, 32'h11,       32'h0,        1, 32'h0,        32'h0,   32'h0,        4'b0000);
      vecs[14] = mk(1, 3'd1, 32'h201, 32'h1234,     32'h0,        1, 32'h0,        32'h0,   32'h0,        4'b0000);
      vecs[15] = mk(0, 3'd5, 32'h105, 32'h0,        32'h0,        1, 32'h0,        32'h0,   32'h0,        4'b0000);
      vecs[16] = mk(0, 3'd2, 32'h3FC, 32'h0,        32'h0BADF00D, 0, 32'h0BADF00D, 32'h3FC, 32'h0,        4'b0000);

      nrst = 1'b0;
      step();
      step();
      check_reset_values("reset");
      nrst = 1'b1;
      step();

      foreach (vecs[i]) do_access(vecs[i], $sformatf("vec%0d", i));

      // Reset while WAITing: request aborted, no response
      drive_req(1'b0, 3'd2, 32'h3F0, 32'h0);
      step();
      i_valid = 1'b0;
      bus_gnt = 1'b1;
      step();
      bus_gnt = 1'b0;
      nrst    = 1'b0;
      step();
      nrst = 1'b1;
      check_reset_values("midreset");
      for (int k = 0; k < 3; k++) begin
         step();
         chk("midreset no response", 32'(o_valid), 32'd0);
      end
      do_access(mk(0, 3'd2, 32'h3F0, 32'h0, 32'h76543210, 0, 32'h76543210, 32'h3F0, 32'h0, 4'b0000),
                "after_reset");

      // Timeout with gnt held low, then a stalled response and a stale rvalid
      drive_req(1'b0, 3'd2, 32'h300, 32'h0);
      sb_q.push_back('{err: 1'b1, data: 32'h0});
      o_ready = 1'b0;
      step();
      i_valid = 1'b0;
      n = 0;
      while (bus_req && n < 20) begin
         n++;
         step();
      end
      chk("timeout bus_req cycles", n, 8);
      chk("timeout o_valid", 32'(o_valid), 32'd1);
      chk("timeout o_error", 32'(o_error), 32'd1);
      held_data = o_data;
      for (int k = 0; k < 5; k++) begin
         bus_rvalid = 1'b1;
         bus_rdata  = 32'hA5A5A5A5;
         step();
         chk("stall o_valid", 32'(o_valid), 32'd1);
         chk("stall o_data", o_data, held_data);
         chk("stall o_error", 32'(o_error), 32'd1);
      end
      bus_rvalid = 1'b0;
      o_ready    = 1'b1;
      check_resp("timeout");
      step();
      chk("timeout release", 32'(o_valid), 32'd0);
      bus_rvalid = 1'b1;
      for (int k = 0; k < 3; k++) begin
         step();
         chk("stale rvalid ignored", 32'(o_valid), 32'd0);
         chk("stale rvalid idle", 32'(i_ready), 32'd1);
      end
      bus_rvalid = 1'b0;

      chk("scoreboard drained", sb_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/ladybird_lsu.md
# ladybird_lsu

Load/store unit between the core's memory stage and the word-oriented data bus. It accepts one load or store per handshake and converts it into an aligned 32-bit bus transaction with byte strobes. Read data is extracted and sign- or zero-extended per funct3. Misaligned addresses, illegal funct3 codes and bus timeouts are reported as error responses instead of reaching the bus.

## Interface
Parameters:
- XLEN, ladybird_config::XLEN (32): datapath width; only 32 is supported.
- TIMEOUT_CYCLES, 256: maximum cycles spent in REQ+WAIT before an error response; 0 disables the timeout.

Ports:
- clk  in  1  clock.
- nrst  in  1  reset, synchronous, active-low.
- i_valid  in  1  request valid from the memory stage.
- i_ready  out  1  LSU can accept a request.
- i_addr  in  XLEN  byte address.
- i_data  in  XLEN  store data, right-aligned.
- i_we  in  1  1 = store, 0 = load.
- i_funct  in  3  RISC-V funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW).
- o_valid  out  1  response valid.
- o_ready  in  1  response consumer ready.
- o_data  out  XLEN  extended load data; 0 for stores and errors.
- o_error  out  1  response is an error; qualified by o_valid.
- bus_req  out  1  bus request.
- bus_gnt  in  1  bus accepts the request in this cycle.
- bus_addr  out  XLEN  word address ({i_addr[XLEN-1:2],2'b00}).
- bus_we  out  1  write enable.
- bus_wdata  out  XLEN  lane-replicated store data.
- bus_strb  out  4  byte strobes (all 0 for loads).
- bus_rvalid  in  1  bus completion (loads and stores).
- bus_rdata  in  XLEN  read word.

## Operation
- States: IDLE, REQ, WAIT, RESP.
- i_ready = (state==IDLE).
- IDLE, i_valid:
  - Request is legal → register addr/we/funct, build bus fields, go to REQ.
  - Request is illegal → o_error=1, o_data=0, go to RESP. No bus activity.
- Legal loads: funct 000, 001, 010, 100, 101. Legal stores: 000, 001, 010. Everything else is an illegal funct.
- Misaligned: halfword with addr[0]=1; word with addr[1:0]≠0.
- Store lanes:
  - SB: wdata = {4{byte}}, strb = 4'b0001 << addr[1:0].
  - SH: wdata = {2{half}}, strb = addr[1] ? 1100 : 0011.
  - SW: strb = 1111.
- REQ: bus_req=1 with stable bus_* fields until bus_gnt, then go to WAIT.
- WAIT: on bus_rvalid, go to RESP. For loads, o_data = selected lane extended (LB/LH sign-extend, LBU/LHU zero-extend, LW passthrough).
- RESP: o_valid=1, outputs held stable until o_ready, then go to IDLE.
- Timeout counter:
  - Cleared on leaving IDLE; counts every cycle in REQ/WAIT.
  - At count==TIMEOUT_CYCLES-1 without completion → RESP with o_error=1, o_data=0, bus_req dropped.
  - A later stale bus_rvalid is ignored.
- bus_rvalid outside WAIT is ignored; bus_gnt outside REQ is ignored.

## Timing
- Reset values: state IDLE, i_ready=1, o_valid=0, o_error=0, o_data=0, bus_req=0, bus_we=0, bus_addr=0, bus_wdata=0, bus_strb=0, timeout count 0.
- All outputs are registered or decoded from state only; there is no combinational path from i_* or bus_* to any output.
- Cycle 0: i_valid&i_ready. Cycle 1: bus_req=1.
- With bus_gnt in cycle 1 and bus_rvalid in cycle 2: o_valid in cycle 3.
- Minimum legal-access latency: 3 cycles.
- Illegal request: o_valid in cycle 1.
- Throughput: one request per ≥2 cycles (RESP → IDLE handshake). With o_ready held high, o_valid is high for exactly one cycle per response.
- bus_gnt and bus_rvalid in the same cycle while in REQ: gnt is taken, rvalid is ignored (WAIT is not yet entered). The bus must not do this.
- Reset mid-transaction (any state): next cycle is IDLE with reset values; no response is produced for the aborted request.

## Structure
- Add lsu_state_t enum (IDLE/REQ/WAIT/RESP) to ladybird_config.
- Add funct3 localparams to ladybird_riscv_helper: FUNCT3_B=000, H=001, W=010, BU=100, HU=101.
- Sub-module ladybird_lsu_align (combinational): store lane replication and strobes, load lane extraction and extension, misalign/illegal detection. Reused later by the core for fault reporting.
- One always_ff for the state, request registers, response registers and timeout counter; one always_comb for next state.

## Test plan
- LW, addr 0x100, bus_rdata 0xDEADBEEF, gnt cycle 1, rvalid cycle 2 → o_valid cycle 3, o_data 0xDEADBEEF, o_error 0.
- LB, addr 0x103, rdata 0x80FF_0000 → o_data 0xFFFFFF80. LBU same → 0x00000080. LH, addr 0x102 → 0xFFFF80FF.
- SB, addr 0x201, i_data 0x12345678 → bus_addr 0x200, wdata 0x78787878, strb 0010, bus_we 1. SH, addr 0x202 → wdata 0x56785678, strb 1100.
- LW, addr 0x102, and funct 011 → error response in cycle 1, o_data 0, bus_req never asserted.
- TIMEOUT_CYCLES=8, bus_gnt held low → o_error after 8 cycles of bus_req; an rvalid injected afterwards produces no extra o_valid. With o_ready low for 5 cycles, o_valid/o_data stay stable.
- nrst asserted while in WAIT → all outputs at reset values next cycle, i_ready=1; a subsequent LW completes normally.
